// File: rtl/id_ex_stage.sv
// ID/EX register feeding the ALU: 1-cycle latency; stall_in holds, flush_in/load-use (stall_out) insert bubbles.
// Optional operand forwarding from EX/MEM and MEM/WB is enabled by defining FORWARD_EN.
module id_ex_stage #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [15:0]     imm16,
  input  logic [size-1:0] rs_data,
  input  logic [size-1:0] rt_data,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            fwd_mem_val,
  input  logic [4:0]      fwd_mem_reg,
  input  logic [size-1:0] fwd_mem_data,
  input  logic            fwd_wb_val,
  input  logic [4:0]      fwd_wb_reg,
  input  logic [size-1:0] fwd_wb_data,
  output logic            stall_out,
  output logic            valid_out,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  output logic [3:0]      alu_ctl,
  output logic [size-1:0] store_data,
  output logic [4:0]      dest_reg,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic            bne,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;

  typedef struct packed {
    logic            valid;
    logic [size-1:0] a;
    logic [size-1:0] b;
    logic [3:0]      ctl;
    logic [size-1:0] store;
    logic [4:0]      dest;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            br;
    logic            bne;
    logic            ill;
  } ex_t;

  ex_t q, d;
  logic [size-1:0] a_op, b_op;
  logic [size-1:0] sext, zext;
  logic            uses_rt;

`ifdef FORWARD_EN
  // EX/MEM is the younger result, so it is applied last and wins.
  always_comb begin
    a_op = rs_data;
    b_op = rt_data;
    if (fwd_wb_val && fwd_wb_reg != 5'd0 && fwd_wb_reg == rs) a_op = fwd_wb_data;
    if (fwd_wb_val && fwd_wb_reg != 5'd0 && fwd_wb_reg == rt) b_op = fwd_wb_data;
    if (fwd_mem_val && fwd_mem_reg != 5'd0 && fwd_mem_reg == rs) a_op = fwd_mem_data;
    if (fwd_mem_val && fwd_mem_reg != 5'd0 && fwd_mem_reg == rt) b_op = fwd_mem_data;
  end
`else
  assign a_op = rs_data;
  assign b_op = rt_data;
  wire unused_fwd = ^{fwd_mem_val, fwd_mem_reg, fwd_mem_data, fwd_wb_val, fwd_wb_reg, fwd_wb_data};
`endif

  assign sext = {{(size-16){imm16[15]}}, imm16};
  assign zext = {{(size-16){1'b0}}, imm16};

  always_comb begin
    d       = '0;
    d.valid = valid_in;
    d.a     = a_op;
    d.b     = b_op;
    d.store = b_op;
    d.ctl   = ALU_BAD;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: d.ctl = ALU_ADD;
          6'h22, 6'h23: d.ctl = ALU_SUB;
          6'h24:        d.ctl = ALU_AND;
          6'h25:        d.ctl = ALU_OR;
          6'h27:        d.ctl = ALU_NOR;
          6'h2A:        d.ctl = ALU_SLT;
          default:      d.ill = 1'b1;
        endcase
        if (!d.ill) begin
          d.dest = rd;
          d.rw   = 1'b1;
        end
      end
      6'h08, 6'h09: begin d.ctl = ALU_ADD; d.b = sext; d.dest = rt; d.rw = 1'b1; end
      6'h0A:        begin d.ctl = ALU_SLT; d.b = sext; d.dest = rt; d.rw = 1'b1; end
      6'h0C:        begin d.ctl = ALU_AND; d.b = zext; d.dest = rt; d.rw = 1'b1; end
      6'h0D:        begin d.ctl = ALU_OR;  d.b = zext; d.dest = rt; d.rw = 1'b1; end
      6'h23:        begin d.ctl = ALU_ADD; d.b = sext; d.dest = rt; d.rw = 1'b1; d.mr = 1'b1; end
      6'h2B:        begin d.ctl = ALU_ADD; d.b = sext; d.mw = 1'b1; end
      6'h04, 6'h05: begin d.ctl = ALU_SUB; d.br = 1'b1; d.bne = opcode[0]; end
      default:      d.ill = 1'b1;
    endcase
    // Writes to r0 are architecturally discarded.
    if (d.dest == 5'd0) d.rw = 1'b0;
  end

  assign uses_rt = (opcode == 6'h00) || (opcode == 6'h2B) || (opcode == 6'h04) || (opcode == 6'h05);

  assign stall_out = q.valid & q.mr & (q.dest != 5'd0) & valid_in &
                     ((q.dest == rs) | (uses_rt & (q.dest == rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        q <= '0;
    else if (flush_in)              q <= '0;
    else if (stall_in)              q <= q;
    else if (stall_out || !valid_in) q <= '0;
    else                            q <= d;
  end

  assign valid_out  = q.valid;
  assign alu_a      = q.a;
  assign alu_b      = q.b;
  assign alu_ctl    = q.ctl;
  assign store_data = q.store;
  assign dest_reg   = q.dest;
  assign reg_write  = q.rw;
  assign mem_read   = q.mr;
  assign mem_write  = q.mw;
  assign is_branch  = q.br;
  assign bne        = q.bne;
  assign illegal    = q.ill;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expected values.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, stall_in, flush_in;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] rs_data, rt_data;
  logic        fwd_mem_val, fwd_wb_val;
  logic [4:0]  fwd_mem_reg, fwd_wb_reg;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        stall_out, valid_out, reg_write, mem_read, mem_write, is_branch, bne, illegal;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_ctl;
  logic [4:0]  dest_reg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.size(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data),
    .stall_in(stall_in), .flush_in(flush_in),
    .fwd_mem_val(fwd_mem_val), .fwd_mem_reg(fwd_mem_reg), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_val(fwd_wb_val), .fwd_wb_reg(fwd_wb_reg), .fwd_wb_data(fwd_wb_data),
    .stall_out(stall_out), .valid_out(valid_out), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctl(alu_ctl), .store_data(store_data), .dest_reg(dest_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .is_branch(is_branch), .bne(bne), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [15:0] imm,
                       input logic [31:0] sd, input logic [31:0] td);
    valid_in = 1'b1; opcode = op; funct = fn; rs = s; rt = t; rd = d;
    imm16 = imm; rs_data = sd; rt_data = td;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    fwd_mem_val = 1'b0; fwd_mem_reg = 5'd0; fwd_mem_data = 32'h0;
    fwd_wb_val = 1'b0; fwd_wb_reg = 5'd0; fwd_wb_data = 32'h0;
    instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h18a0, 32'd5, 32'd7);
    step();
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_ctl", {28'b0, alu_ctl}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_stall", {31'b0, stall_out}, 32'd0);

    // add r3 = r1 + r2
    rst = 1'b0;
    step();
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_ctl", {28'b0, alu_ctl}, 32'd2);
    check("add_dest", {27'b0, dest_reg}, 32'd3);
    check("add_rw", {31'b0, reg_write}, 32'd1);
    check("add_valid", {31'b0, valid_out}, 32'd1);
    check("add_store", store_data, 32'd7);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, valid_out}, 32'd0);
    check("arst_a", alu_a, 32'd0);
    check("arst_rw", {31'b0, reg_write}, 32'd0);
    rst = 1'b0;

    instr(6'h0C, 6'h3f, 5'd1, 5'd5, 5'd31, 16'hFFFF, 32'h12345678, 32'h0);
    step();
    check("andi_b", alu_b, 32'h0000FFFF);
    check("andi_ctl", {28'b0, alu_ctl}, 32'd0);
    check("andi_a", alu_a, 32'h12345678);
    check("andi_dest", {27'b0, dest_reg}, 32'd5);

    instr(6'h08, 6'h3f, 5'd1, 5'd5, 5'd31, 16'hFFFF, 32'h12345678, 32'h0);
    step();
    check("addi_b", alu_b, 32'hFFFFFFFF);
    check("addi_ctl", {28'b0, alu_ctl}, 32'd2);

    // load-use hazard
    instr(6'h23, 6'h08, 5'd1, 5'd4, 5'd0, 16'h0008, 32'h100, 32'h0);
    step();
    check("lw_mr", {31'b0, mem_read}, 32'd1);
    check("lw_dest", {27'b0, dest_reg}, 32'd4);
    check("lw_b", alu_b, 32'd8);
    instr(6'h00, 6'h20, 5'd4, 5'd2, 5'd6, 16'h3020, 32'd1, 32'd2);
    #1;
    check("lu_stall", {31'b0, stall_out}, 32'd1);
    step();
    check("lu_bubble", {31'b0, valid_out}, 32'd0);
    check("lu_stall_clr", {31'b0, stall_out}, 32'd0);
    step();
    check("lu_resume", {31'b0, valid_out}, 32'd1);
    check("lu_dest", {27'b0, dest_reg}, 32'd6);

    // load to r0 never stalls
    instr(6'h23, 6'h08, 5'd1, 5'd0, 5'd0, 16'h0008, 32'h100, 32'h0);
    step();
    check("lw0_rw", {31'b0, reg_write}, 32'd0);
    instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd6, 16'h3020, 32'd1, 32'd2);
    #1;
    check("lw0_stall", {31'b0, stall_out}, 32'd0);

    // hold under stall_in, then flush wins over stall
    instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h18a0, 32'd5, 32'd7);
    step();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr(6'h00, 6'h22, 5'd9, 5'd10, 5'd11, 16'h5822, 32'd99 + i, 32'd42);
      step();
      check("hold_a", alu_a, 32'd5);
      check("hold_ctl", {28'b0, alu_ctl}, 32'd2);
      check("hold_dest", {27'b0, dest_reg}, 32'd3);
    end
    flush_in = 1'b1;
    step();
    check("flush_valid", {31'b0, valid_out}, 32'd0);
    check("flush_a", alu_a, 32'd0);
    check("flush_rw", {31'b0, reg_write}, 32'd0);
    stall_in = 1'b0; flush_in = 1'b0;

    // forwarding priority
    instr(6'h00, 6'h20, 5'd6, 5'd2, 5'd3, 16'h18a0, 32'h11, 32'h22);
    fwd_mem_val = 1'b1; fwd_mem_reg = 5'd6; fwd_mem_data = 32'hAA;
    fwd_wb_val = 1'b1; fwd_wb_reg = 5'd6; fwd_wb_data = 32'hBB;
    step();
`ifdef FORWARD_EN
    check("fwd_mem_a", alu_a, 32'hAA);
`else
    check("fwd_mem_a", alu_a, 32'h11);
`endif
    fwd_mem_val = 1'b0;
    step();
`ifdef FORWARD_EN
    check("fwd_wb_a", alu_a, 32'hBB);
`else
    check("fwd_wb_a", alu_a, 32'h11);
`endif
    check("fwd_b", alu_b, 32'h22);
    fwd_wb_val = 1'b0;

    instr(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 16'h1800, 32'd1, 32'd2);
    step();
    check("ill_flag", {31'b0, illegal}, 32'd1);
    check("ill_ctl", {28'b0, alu_ctl}, 32'd15);
    check("ill_rw", {31'b0, reg_write}, 32'd0);
    check("ill_valid", {31'b0, valid_out}, 32'd1);

    instr(6'h00, 6'h27, 5'd1, 5'd2, 5'd3, 16'h1827, 32'd1, 32'd2);
    step();
    check("nor_ctl", {28'b0, alu_ctl}, 32'd12);
    check("nor_ill", {31'b0, illegal}, 32'd0);

    instr(6'h00, 6'h2A, 5'd1, 5'd2, 5'd3, 16'h182A, 32'd1, 32'd2);
    step();
    check("slt_ctl", {28'b0, alu_ctl}, 32'd7);

    instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 16'h0020, 32'd1, 32'd2);
    step();
    check("r0_rw", {31'b0, reg_write}, 32'd0);

    instr(6'h2B, 6'h04, 5'd1, 5'd2, 5'd0, 16'hFFFC, 32'h200, 32'hCAFE);
    step();
    check("sw_mw", {31'b0, mem_write}, 32'd1);
    check("sw_store", store_data, 32'hCAFE);
    check("sw_b", alu_b, 32'hFFFFFFFC);
    check("sw_rw", {31'b0, reg_write}, 32'd0);

    instr(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0010, 32'd3, 32'd4);
    step();
    check("beq_br", {31'b0, is_branch}, 32'd1);
    check("beq_bne", {31'b0, bne}, 32'd0);
    check("beq_ctl", {28'b0, alu_ctl}, 32'd6);
    check("beq_b", alu_b, 32'd4);

    instr(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0010, 32'd3, 32'd4);
    step();
    check("bne_bne", {31'b0, bne}, 32'd1);

    valid_in = 1'b0;
    step();
    check("novalid", {31'b0, valid_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures a decoded instruction's register operands and immediate, selects operand B, and generates the 4-bit ALU control code.
- Launches alu_a/alu_b/alu_ctl into the execute stage.
- Includes load-use hazard detection, and bubble/hold/flush control driven by the hazard unit.

Parameters:
- size, 32, datapath width of operands and forwarded results.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  decode stage holds a real instruction.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- rs  in  5  instr[25:21].
- rt  in  5  instr[20:16].
- rd  in  5  instr[15:11].
- imm16  in  16  instr[15:0].
- rs_data  in  size  register file read port A.
- rt_data  in  size  register file read port B.
- stall_in  in  1  downstream stall; hold all contents.
- flush_in  in  1  branch redirect; kill the contents.
- fwd_mem_val  in  1  EX/MEM result is writing a register.
- fwd_mem_reg  in  5  its destination register.
- fwd_mem_data  in  size  its result.
- fwd_wb_val  in  1  MEM/WB result is writing a register.
- fwd_wb_reg  in  5  its destination register.
- fwd_wb_data  in  size  its result.
- stall_out  out  1  load-use hazard; IF/ID must hold (combinational).
- valid_out  out  1  ALU operands are a real instruction.
- alu_a  out  size  ALU operand A.
- alu_b  out  size  ALU operand B.
- alu_ctl  out  4  ALU control code.
- store_data  out  size  rt value carried for sw.
- dest_reg  out  5  writeback register index.
- reg_write  out  1  writeback enable.
- mem_read  out  1  load in flight.
- mem_write  out  1  store in flight.
- is_branch  out  1  beq/bne; the branch sense is carried in bne.
- bne  out  1  branch sense.
- illegal  out  1  unknown opcode/funct was latched.

Behaviour:
- Reset: all outputs are 0 while rst is high and immediately on assertion, with no clock needed. This includes alu_ctl=0.
- Update priority at each posedge:
  - rst
  - flush_in: load a bubble (all registered outputs 0).
  - stall_in: hold every register.
  - stall_out: load a bubble.
  - otherwise: load the decoded instruction. If valid_in=0, load a bubble.
- Latency: 1 cycle from decode inputs to outputs.
- stall_out = valid_out & mem_read & dest_reg!=0 & valid_in & (dest_reg==rs | (uses_rt & dest_reg==rt)).
  - uses_rt is true for R-type, sw, beq and bne.
- ALU control codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12. Undefined operations give 15 (ALU outputs 0).
- R-type (opcode 0):
  - funct 0x20/0x21 → ADD
  - funct 0x22/0x23 → SUB
  - funct 0x24 → AND
  - funct 0x25 → OR
  - funct 0x27 → NOR
  - funct 0x2A → SLT
  - alu_b = rt operand; dest=rd; reg_write=1.
- I-type (dest=rt, reg_write=1):
  - addi 0x08 / addiu 0x09 → ADD, imm sign-extended.
  - slti 0x0A → SLT, imm sign-extended.
  - andi 0x0C → AND, imm zero-extended.
  - ori 0x0D → OR, imm zero-extended.
- lw 0x23: ADD with sign-extended imm; mem_read=1; dest=rt; reg_write=1.
- sw 0x2B: ADD with sign-extended imm; mem_write=1; reg_write=0.
- beq 0x04 / bne 0x05: SUB of the rs/rt operands; is_branch=1; bne set for 0x05; reg_write=0.
- Unknown opcode/funct: alu_ctl=15; reg_write=mem_read=mem_write=is_branch=0; illegal=1; valid_out follows valid_in.
- Destination register 0: reg_write is forced to 0.
- store_data always equals the resolved rt operand.
- A stall_in held across multiple cycles leaves all outputs bit-stable.
- A flush_in asserted together with stall_in still flushes.

Optional Feature:
- Macro FORWARD_EN.
- Defined: the rs and rt operands are resolved before latching.
  - EX/MEM match (valid, reg!=0, reg==idx) wins first.
  - Then MEM/WB match.
  - Else register file data.
- Undefined: the fwd_* ports are ignored and operands come from rs_data/rt_data only. The ports remain present in both builds.

Test Plan:
- Reset, then clock: add rs=1 (5), rt=2 (7), rd=3 → next cycle alu_a=5, alu_b=7, alu_ctl=2, dest_reg=3, reg_write=1; rst pulse mid-cycle clears all outputs asynchronously.
- andi imm=0xFFFF, rs_data=0x12345678 → alu_b=0x0000FFFF, alu_ctl=0. addi imm=0xFFFF → alu_b=0xFFFFFFFF, alu_ctl=2.
- lw dest=4 latched, next decode add rs=4 → stall_out=1, following cycle valid_out=0; same case with dest=0 → stall_out=0.
- stall_in high 3 cycles with changing inputs → outputs unchanged. stall_in together with flush_in → bubble.
- FORWARD_EN: rs=6, fwd_mem (6, 0xAA), fwd_wb (6, 0xBB) → alu_a=0xAA. Without the macro → alu_a=rs_data.
- opcode 0x3F → illegal=1, alu_ctl=15, reg_write=0. R-type funct 0x27 → alu_ctl=12.
